// File: rtl/exp_ctrl.sv
// LSB-first square-and-multiply controller for y = x^n mod 2^W; one cycle per COND, one per DONE.
// Each multiply state lasts until mul_ack (zero extra cycles if acked combinationally); start is ignored while busy.
module exp_ctrl #(
  parameter int W  = 16,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x,
  input  logic [NW-1:0] n,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  y,
  output logic          mul_req,
  output logic [W-1:0]  mul_a,
  output logic [W-1:0]  mul_b,
  input  logic          mul_ack,
  input  logic [W-1:0]  mul_p
);

  typedef enum logic [2:0] {
    S_INIT,
    S_COND,
    S_MULR,
    S_SQR,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  res;
  logic [W-1:0]  base;
  logic [W-1:0]  y_q;
  logic [NW-1:0] e;
  logic          e_last;

  // No bits above the LSB left: the multiply in MULR is the final one.
  assign e_last = (e[NW-1:1] == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_INIT);
    done      = 1'b0;
    mul_req   = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      S_INIT: begin
        if (start) state_nxt = S_COND;
      end
      S_COND: begin
        if (e == '0)     state_nxt = S_DONE;
        else if (e[0])   state_nxt = S_MULR;
        else             state_nxt = S_SQR;
      end
      S_MULR: begin
        mul_req = 1'b1;
        mul_a   = res;
        mul_b   = base;
        if (mul_ack) state_nxt = e_last ? S_DONE : S_SQR;
      end
      S_SQR: begin
        mul_req = 1'b1;
        mul_a   = base;
        mul_b   = base;
        if (mul_ack) state_nxt = S_COND;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_INIT;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // res is already final on entry to DONE, so bypass it onto y for that cycle.
  assign y = done ? res : y_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res  <= '0;
      base <= '0;
      e    <= '0;
      y_q  <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (start) begin
            res  <= W'(1);
            base <= x;
            e    <= n;
          end
        end
        S_MULR: begin
          if (mul_ack) begin
            res <= mul_p;
            if (e_last) e <= '0;
          end
        end
        S_SQR: begin
          if (mul_ack) begin
            base <= mul_p;
            e    <= e >> 1;
          end
        end
        S_DONE: y_q <= res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_ctrl.sv
// Bench for exp_ctrl: directed and random exponentiations against a reference model,
// with a multiplier stub whose ack latency is programmable per operation.
module tb_exp_ctrl;
  localparam int W  = 16;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  x = '0;
  logic [NW-1:0] n = '0;
  logic          busy, done, mul_req, mul_ack;
  logic [W-1:0]  y, mul_a, mul_b, mul_p;

  int checks = 0;
  int errors = 0;

  exp_ctrl #(.W(W), .NW(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .n(n),
    .busy(busy), .done(done), .y(y),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ack(mul_ack), .mul_p(mul_p)
  );

  always #5 clk = ~clk;

  // Multiplier stub: acks after ack_delay waiting cycles.
  int ack_delay = 0;
  int wait_cnt;
  assign mul_ack = mul_req && (wait_cnt >= ack_delay);
  assign mul_p   = mul_a * mul_b;
  always @(posedge clk or negedge rst) begin
    if (!rst)                     wait_cnt <= 0;
    else if (mul_req && !mul_ack) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
  end

  // Transaction monitor, sampled on the falling edge.
  bit           mon_en = 0;
  int           busy_cycles, done_cnt, hold, stab_err;
  bit           hold_pending;
  logic [W-1:0] last_a, last_b;
  logic [W-1:0] txa[$], txb[$];
  int           holds[$];
  logic [W-1:0] exp_a[$], exp_b[$];

  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (mul_req) hold++;
      if (hold_pending && (!mul_req || mul_a !== last_a || mul_b !== last_b)) stab_err++;
      if (mul_req && mul_ack) begin
        txa.push_back(mul_a);
        txb.push_back(mul_b);
        holds.push_back(hold);
        hold = 0;
        hold_pending = 0;
      end else if (mul_req) begin
        hold_pending = 1;
        last_a = mul_a;
        last_b = mul_b;
      end
    end
  end

  task automatic clear_mon();
    busy_cycles = 0; done_cnt = 0; hold = 0; stab_err = 0; hold_pending = 0;
    txa.delete(); txb.delete(); holds.delete();
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Reference: plain repeated multiplication, truncated to W bits.
  function automatic logic [W-1:0] pow_ref(input logic [W-1:0] b, input int e);
    logic [W-1:0] r = W'(1);
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Expected multiply operand list from the square-and-multiply rules.
  task automatic build_seq(input logic [W-1:0] xi, input int ni);
    logic [W-1:0] r = W'(1);
    logic [W-1:0] b = xi;
    int e = ni;
    exp_a.delete(); exp_b.delete();
    while (e != 0) begin
      if (e % 2 == 1) begin
        exp_a.push_back(r); exp_b.push_back(b);
        r = r * b;
        if (e / 2 == 0) break;
      end
      exp_a.push_back(b); exp_b.push_back(b);
      b = b * b;
      e = e / 2;
    end
  endtask

  function automatic int exp_latency(input int ni, input int dly);
    int bits = 0;
    int ones = 0;
    for (int v = ni; v != 0; v = v / 2) begin
      bits++;
      ones += v % 2;
    end
    if (ni == 0) return 2;
    return bits + (ones + bits - 1) * (dly + 1) + 1;
  endfunction

  task automatic run_op(input logic [W-1:0] xi, input int ni, input int dly, input bit inject);
    logic [W-1:0] ey;
    int lat, k, bad;
    ey  = pow_ref(xi, ni);
    lat = exp_latency(ni, dly);
    build_seq(xi, ni);
    ack_delay = dly;
    @(posedge clk); #1;
    clear_mon();
    mon_en = 1;
    @(negedge clk);
    start = 1'b1; x = xi; n = NW'(ni);
    @(negedge clk);
    start = 1'b0; x = W'($urandom); n = NW'($urandom);
    k = 1;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
      start = inject && (k == 2);
      if (inject) x = W'(7);
    end
    chk("done_latency", k, lat);
    chk("y_at_done", y, ey);
    start = 1'b0;
    @(negedge clk);
    chk("y_hold", y, ey);
    chk("done_single_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    repeat (lat + 2) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("busy_cycles", busy_cycles, lat);
    chk("mul_count", txa.size(), exp_a.size());
    bad = 0;
    for (int i = 0; i < txa.size() && i < exp_a.size(); i++) begin
      if (txa[i] !== exp_a[i] || txb[i] !== exp_b[i]) bad++;
      if (holds[i] != dly + 1) bad++;
    end
    chk("mul_operands_and_hold", bad, 0);
    chk("mul_stability", stab_err, 0);
    mon_en = 0;
  endtask

  initial begin
    int k;
    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y", y, 0);
    chk("rst_mul_req", mul_req, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed cases
    run_op(W'(3), 0, 0, 0);
    run_op(W'(3), 5, 0, 0);
    run_op(W'(3), 11, 0, 0);
    run_op(W'(2), 20, 0, 0);
    run_op(W'(0), 0, 0, 0);
    run_op(W'(0), 7, 1, 0);
    run_op(W'(5), 3, 3, 1);

    // Asynchronous reset while a squaring request is pending
    ack_delay = 3;
    @(negedge clk);
    start = 1'b1; x = W'(5); n = NW'(2);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_mul_req", mul_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mul_req", mul_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_y", y, 0);
    chk("arst_mul_a", mul_a, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op(W'(5), 2, 0, 0);

    // start held high: back-to-back operations
    ack_delay = 0;
    @(posedge clk); #1;
    clear_mon();
    mon_en = 1;
    @(negedge clk);
    start = 1'b1; x = W'(2); n = NW'(4);
    for (int op = 0; op < 2; op++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done && k < 3000);
      chk("held_latency", k, exp_latency(4, 0));
      chk("held_y", y, pow_ref(W'(2), 4));
      if (op == 1) start = 1'b0;
      @(negedge clk);
      chk("held_idle_busy", busy, 0);
      chk("held_idle_y", y, 16);
    end
    repeat (10) @(negedge clk);
    chk("held_done_count", done_cnt, 2);
    mon_en = 0;

    // Random operands, exponents and multiplier stalls
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), $urandom_range(0, 255), $urandom_range(0, 2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
